bcd_display_scanner: RTL and testbench



---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/refresh_prescaler.sv | 28 ++
 rtl/bcd_display_scanner.sv | 109 ++++++++++
 tb/tb_bcd_display_scanner.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment constants, display payload type and BCD decoder shared by the scanner.
package seg7_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 8;

  // Active-low segment patterns, bit order a..g = [6:0]
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;

  // One full display value: packed BCD digits plus per-digit decimal points
  typedef struct packed {
    logic [MAX_DIGITS*DIGIT_W-1:0] bcd;
    logic [MAX_DIGITS-1:0]         dp;
  } disp_word_t;

  // Non-decimal nibbles render as a dash so bad data is visible
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [DIGIT_W-1:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Digit-slot timer: emits a one-cycle tick every DIV enabled clocks.
module refresh_prescaler #(
  parameter int unsigned DIV = 100_000
) (
  input  logic CLK100MHZ,
  input  logic Resetn,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..DIV-1 while enabled; hold the count when frozen
  always_ff @(posedge CLK100MHZ or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Gated by enable so a frozen count sitting on LAST cannot advance the scan
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with frame-aligned double buffering.
module bcd_display_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned DIGITS      = 8
) (
  input  logic                          CLK100MHZ,
  input  logic                          Resetn,
  input  logic                          enable,
  input  logic                          load,
  input  logic [MAX_DIGITS*DIGIT_W-1:0] bcd_in,
  input  logic [MAX_DIGITS-1:0]         dp_in,
  input  logic                          blank_lz,
  output logic [SEG_W-1:0]              C,
  output logic                          DP,
  output logic [MAX_DIGITS-1:0]         AN,
  output logic                          pending,
  output logic                          frame_tick
);

  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic                  tick;
  logic                  wrap;
  logic [IDX_W-1:0]      idx;
  disp_word_t            load_word;
  disp_word_t            buffer;
  disp_word_t            shadow;
  logic                  nz_seen;
  logic [MAX_DIGITS-1:0] lz_blank;
  logic [DIGIT_W-1:0]    cur_nibble;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .CLK100MHZ (CLK100MHZ),
    .Resetn    (Resetn),
    .enable    (enable),
    .tick      (tick)
  );

  assign load_word  = {bcd_in, dp_in};
  assign wrap       = tick && (idx == LAST_IDX);
  assign cur_nibble = shadow.bcd[{idx, 2'b00} +: DIGIT_W];

  // Scan index advance and frame boundary pulse
  always_ff @(posedge CLK100MHZ or negedge Resetn) begin
    if (!Resetn) begin
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Double buffer: loads land in buffer, shadow only changes at a frame wrap
  always_ff @(posedge CLK100MHZ or negedge Resetn) begin
    if (!Resetn) begin
      buffer  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (load && wrap) begin
      buffer  <= load_word;
      shadow  <= load_word;
      pending <= 1'b0;
    end else if (load) begin
      buffer  <= load_word;
      pending <= 1'b1;
    end else if (wrap && pending) begin
      shadow  <= buffer;
      pending <= 1'b0;
    end
  end

  // Leading-zero mask: a digit blanks when it and every active digit above it are zero
  always_comb begin
    nz_seen  = 1'b0;
    lz_blank = '0;
    for (int k = int'(MAX_DIGITS) - 1; k >= 0; k--) begin
      if (k < int'(DIGITS)) begin
        nz_seen     = nz_seen | (shadow.bcd[k*DIGIT_W +: DIGIT_W] != '0);
        lz_blank[k] = blank_lz && !nz_seen && (k != 0);
      end
    end
  end

  // Registered display drive; blank everything while frozen
  always_ff @(posedge CLK100MHZ or negedge Resetn) begin
    if (!Resetn) begin
      AN <= '1;
      C  <= SEG_BLANK;
      DP <= 1'b1;
    end else if (!enable) begin
      AN <= '1;
      C  <= SEG_BLANK;
      DP <= 1'b1;
    end else begin
      AN <= ~(MAX_DIGITS'(1) << idx);
      C  <= lz_blank[idx] ? SEG_BLANK : bcd_to_seg(cur_nibble);
      DP <= ~shadow.dp[idx];
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed, table-driven bench for bcd_display_scanner at REFRESH_DIV=4, DIGITS=8.
module tb_bcd_display_scanner;

  localparam int unsigned DIV = 4;
  localparam int unsigned ND  = 8;

  logic        clk;
  logic        Resetn;
  logic        enable;
  logic        load;
  logic [31:0] bcd_in;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  C;
  logic        DP;
  logic [7:0]  AN;
  logic        pending;
  logic        frame_tick;

  int n_vec;
  int n_err;
  int cyc;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  dp;
    logic        lz;
    int          digit;
    logic [6:0]  c;
    logic        dpo;
  } vec_t;

  vec_t tab[$];

  bcd_display_scanner #(
    .REFRESH_DIV (DIV),
    .DIGITS      (ND)
  ) dut (
    .CLK100MHZ  (clk),
    .Resetn     (Resetn),
    .enable     (enable),
    .load       (load),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .C          (C),
    .DP         (DP),
    .AN         (AN),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [31:0] b, input logic [7:0] d);
    bcd_in = b;
    dp_in  = d;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  // Wait for the buffered value to reach the shadow, then one more edge for the outputs
  task automatic settle();
    for (int i = 0; i < 100 && pending; i++) step();
    chk("pending_clears", 32'(pending), 32'd0);
    step();
  endtask

  task automatic wait_an(input logic [7:0] target, input string nm);
    for (int i = 0; i < 40 && AN !== target; i++) step();
    chk(nm, 32'(AN), 32'(target));
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 100 && frame_tick !== 1'b1; i++) step();
    chk("frame_tick_seen", 32'(frame_tick), 32'd1);
  endtask

  initial begin
    logic [7:0] an_exp;
    n_vec    = 0;
    n_err    = 0;
    Resetn   = 1'b0;
    enable   = 1'b1;
    load     = 1'b0;
    bcd_in   = '0;
    dp_in    = '0;
    blank_lz = 1'b0;

    tab.push_back('{32'h12345678, 8'h00, 1'b0, 0, 7'b0000000, 1'b1});
    tab.push_back('{32'h12345678, 8'h00, 1'b0, 3, 7'b0100100, 1'b1});
    tab.push_back('{32'h12345678, 8'h00, 1'b0, 7, 7'b1001111, 1'b1});
    tab.push_back('{32'h00000405, 8'h00, 1'b1, 0, 7'b0100100, 1'b1});
    tab.push_back('{32'h00000405, 8'h00, 1'b1, 1, 7'b0000001, 1'b1});
    tab.push_back('{32'h00000405, 8'h00, 1'b1, 2, 7'b1001100, 1'b1});
    tab.push_back('{32'h00000405, 8'h00, 1'b1, 3, 7'b1111111, 1'b1});
    tab.push_back('{32'h00000405, 8'h00, 1'b1, 7, 7'b1111111, 1'b1});
    tab.push_back('{32'h00000405, 8'h00, 1'b0, 3, 7'b0000001, 1'b1});
    tab.push_back('{32'h00000405, 8'h00, 1'b0, 7, 7'b0000001, 1'b1});
    tab.push_back('{32'h00000A00, 8'h04, 1'b0, 2, 7'b1111110, 1'b0});
    tab.push_back('{32'h00000A00, 8'h04, 1'b0, 1, 7'b0000001, 1'b1});
    tab.push_back('{32'h00000A00, 8'h04, 1'b0, 3, 7'b0000001, 1'b1});
    tab.push_back('{32'h00000000, 8'h00, 1'b1, 0, 7'b0000001, 1'b1});
    tab.push_back('{32'h00000000, 8'h00, 1'b1, 1, 7'b1111111, 1'b1});
    tab.push_back('{32'h00000001, 8'h80, 1'b1, 7, 7'b1111111, 1'b0});
    tab.push_back('{32'h90000000, 8'h00, 1'b1, 6, 7'b0000001, 1'b1});
    tab.push_back('{32'h90000000, 8'h00, 1'b1, 7, 7'b0000100, 1'b1});
    tab.push_back('{32'h07000000, 8'h00, 1'b0, 6, 7'b0001111, 1'b1});
    tab.push_back('{32'h00060000, 8'h00, 1'b0, 4, 7'b0100000, 1'b1});
    tab.push_back('{32'h00000020, 8'h00, 1'b0, 1, 7'b0010010, 1'b1});
    tab.push_back('{32'h00000003, 8'h00, 1'b0, 0, 7'b0000110, 1'b1});
    tab.push_back('{32'h0000F000, 8'h00, 1'b0, 3, 7'b1111110, 1'b1});
    tab.push_back('{32'h000B0000, 8'h00, 1'b1, 4, 7'b1111110, 1'b1});
    tab.push_back('{32'h000B0000, 8'h00, 1'b1, 5, 7'b1111111, 1'b1});

    // Reset state
    repeat (3) step();
    chk("rst_an", 32'(AN), 32'hFF);
    chk("rst_c", 32'(C), 32'h7F);
    chk("rst_dp", 32'(DP), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_frame_tick", 32'(frame_tick), 32'd0);

    // Buffered load at cycle 2 after release, frame wrap at cycle 31
    Resetn = 1'b1;
    cyc = 0;
    step(); cyc++;
    step(); cyc++;
    load_val(32'h12345678, 8'h00); cyc++;
    chk("bl_pending_set", 32'(pending), 32'd1);
    while (cyc < 64) begin
      step(); cyc++;
      case (cyc)
        31: begin
          chk("bl_pending_c31", 32'(pending), 32'd1);
          chk("bl_ftick_c31", 32'(frame_tick), 32'd0);
        end
        32: begin
          chk("bl_ftick_c32", 32'(frame_tick), 32'd1);
          chk("bl_pending_c32", 32'(pending), 32'd0);
        end
        33: begin
          chk("bl_ftick_c33", 32'(frame_tick), 32'd0);
          chk("bl_d0_an", 32'(AN), 32'hFE);
          chk("bl_d0_c", 32'(C), 32'(7'b0000000));
        end
        45: begin
          chk("bl_d3_an", 32'(AN), 32'hF7);
          chk("bl_d3_c", 32'(C), 32'(7'b0100100));
        end
        61: begin
          chk("bl_d7_an", 32'(AN), 32'h7F);
          chk("bl_d7_c", 32'(C), 32'(7'b1001111));
        end
        default: ;
      endcase
    end

    // Table of digit/segment vectors
    foreach (tab[i]) begin
      blank_lz = tab[i].lz;
      load_val(tab[i].bcd, tab[i].dp);
      settle();
      an_exp = ~(8'(1) << tab[i].digit);
      wait_an(an_exp, $sformatf("tab%0d_an", i));
      chk($sformatf("tab%0d_c", i), 32'(C), 32'(tab[i].c));
      chk($sformatf("tab%0d_dp", i), 32'(DP), 32'(tab[i].dpo));
    end
    blank_lz = 1'b0;

    // Two loads while pending: last write wins
    wait_frame();
    load_val(32'h11111111, 8'h00);
    load_val(32'h22222222, 8'h00);
    chk("lww_pending", 32'(pending), 32'd1);
    settle();
    wait_an(8'hFE, "lww_an");
    chk("lww_c", 32'(C), 32'(7'b0010010));

    // Load on the wrap-tick cycle bypasses into the new frame
    wait_frame();
    repeat (31) step();
    load_val(32'h33333333, 8'h00);
    chk("wl_pending", 32'(pending), 32'd0);
    chk("wl_ftick", 32'(frame_tick), 32'd1);
    step();
    chk("wl_an", 32'(AN), 32'hFE);
    chk("wl_c", 32'(C), 32'(7'b0000110));

    // Freeze at digit 5, load while frozen, resume with the same slot remainder
    wait_frame();
    repeat (21) step();
    chk("en_pre_an", 32'(AN), 32'hDF);
    enable = 1'b0;
    step();
    chk("en_off_an", 32'(AN), 32'hFF);
    chk("en_off_c", 32'(C), 32'h7F);
    chk("en_off_dp", 32'(DP), 32'd1);
    load_val(32'h44444444, 8'h00);
    repeat (18) step();
    chk("en_off_pending", 32'(pending), 32'd1);
    chk("en_off_an_held", 32'(AN), 32'hFF);
    chk("en_off_ftick", 32'(frame_tick), 32'd0);
    enable = 1'b1;
    step();
    chk("en_on_an1", 32'(AN), 32'hDF);
    step();
    step();
    chk("en_on_an3", 32'(AN), 32'hDF);
    step();
    chk("en_on_an4", 32'(AN), 32'hBF);
    settle();
    wait_an(8'hFE, "en_xfer_an");
    chk("en_xfer_c", 32'(C), 32'(7'b1001100));

    // Asynchronous reset mid-scan with a load pending
    wait_frame();
    load_val(32'h55555555, 8'h00);
    chk("mr_pending_pre", 32'(pending), 32'd1);
    repeat (5) step();
    #2;
    Resetn = 1'b0;
    #1;
    chk("mr_an", 32'(AN), 32'hFF);
    chk("mr_c", 32'(C), 32'h7F);
    chk("mr_dp", 32'(DP), 32'd1);
    chk("mr_pending", 32'(pending), 32'd0);
    repeat (2) step();
    Resetn = 1'b1;
    step();
    chk("rel_an1", 32'(AN), 32'hFE);
    chk("rel_c1", 32'(C), 32'(7'b0000001));
    repeat (3) step();
    chk("rel_an4", 32'(AN), 32'hFE);
    step();
    chk("rel_an5", 32'(AN), 32'hFD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
